debounce_timer: RTL and testbench

DEBOUNCE_TIMER -- requirements
Module: debounce_timer

---
 rtl/debounce_timer_if.sv | 24 ++
 rtl/debounce_timer.sv | 135 +++++++++++++
 tb/tb_debounce_timer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/debounce_timer_if.sv
// Handshake bundle between the debounce FSM and the settle timer.
//   master (debounce FSM side): drives timerstart, tc_load, tc_value;
//                               observes timerOF, busy, count.
//   slave  (timer side)       : the reverse directions.
interface debounce_timer_if #(
  parameter int CNT_W = 20
) ();
  logic             timerstart;  // run request, held high while waiting to settle
  logic             tc_load;     // one-cycle strobe to capture tc_value
  logic [CNT_W-1:0] tc_value;    // new terminal count, unsigned
  logic             timerOF;     // one-cycle expiry pulse
  logic             busy;        // timer is in RUN or EXPIRED
  logic [CNT_W-1:0] count;       // current tick count, 0 outside RUN

  modport master (
    output timerstart, tc_load, tc_value,
    input  timerOF, busy, count
  );

  modport slave (
    input  timerstart, tc_load, tc_value,
    output timerOF, busy, count
  );
endinterface

// File: rtl/debounce_timer.sv
// Settle timer for a switch debouncer. While timerstart is held high the
// timer counts tc_reg ticks (one tick every PRESCALE clocks) and then emits
// a single-cycle timerOF pulse. Dropping timerstart aborts the run at once.
// A new terminal count may be loaded at any time; loads arriving mid-run are
// parked and applied on the next IDLE cycle so the current run is unaffected.
//
// Ports:
//   clk    : system clock, rising-edge
//   rst    : synchronous, active-high reset
//   tmr_if : debounce_timer_if.slave (timerstart, tc_load, tc_value in;
//            timerOF, busy, count out -- all outputs registered)
module debounce_timer #(
  parameter int CNT_W      = 20,
  parameter int DEFAULT_TC = 1000000,
  parameter int PRESCALE   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  debounce_timer_if.slave      tmr_if
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [PS_W-1:0]  pre_q;
  logic [CNT_W-1:0] tc_q;
  logic [CNT_W-1:0] pend_q;
  logic             pend_vld_q;
  logic             timerof_q;
  logic             busy_q;

  logic             tick;
  logic             terminal;
  logic [CNT_W-1:0] tc_value_d;

  // A terminal count of zero would never expire; treat it as one tick.
  function automatic logic [CNT_W-1:0] sat_tc(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign tc_value_d = sat_tc(tmr_if.tc_value);
  assign tick       = (pre_q == PS_W'(PRESCALE - 1));
  // >= rather than == keeps the counter from ever running past tc_reg-1.
  assign terminal   = (count_q >= (tc_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pre_q      <= '0;
      tc_q       <= CNT_W'(DEFAULT_TC);
      pend_vld_q <= 1'b0;
      timerof_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      timerof_q <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= '0;
          pre_q   <= '0;
          // A direct load in this cycle is newer than any parked value.
          if (tmr_if.tc_load) begin
            tc_q       <= tc_value_d;
            pend_vld_q <= 1'b0;
          end else if (pend_vld_q) begin
            tc_q       <= pend_q;
            pend_vld_q <= 1'b0;
          end
          if (tmr_if.timerstart) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        RUN: begin
          if (tmr_if.tc_load) begin
            pend_q     <= tc_value_d;
            pend_vld_q <= 1'b1;
          end
          // Abort wins over a simultaneous terminal tick.
          if (!tmr_if.timerstart) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
            busy_q  <= 1'b0;
          end else if (tick) begin
            pre_q <= '0;
            if (terminal) begin
              state_q   <= EXPIRED;
              count_q   <= '0;
              timerof_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end else begin
            pre_q <= pre_q + PS_W'(1);
          end
        end

        EXPIRED: begin
          if (tmr_if.tc_load) begin
            pend_q     <= tc_value_d;
            pend_vld_q <= 1'b1;
          end
          state_q <= IDLE;
          count_q <= '0;
          pre_q   <= '0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          count_q <= '0;
          pre_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tmr_if.timerOF = timerof_q;
  assign tmr_if.busy    = busy_q;
  assign tmr_if.count   = count_q;

endmodule

// File: tb/tb_debounce_timer.sv
module tb_debounce_timer;

  localparam int CNT_W = 8;
  localparam int DEF   = 6;
  localparam int MP    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  debounce_timer_if #(.CNT_W(CNT_W)) b1 ();
  debounce_timer_if #(.CNT_W(CNT_W)) b3 ();

  debounce_timer #(.CNT_W(CNT_W), .DEFAULT_TC(DEF), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .tmr_if(b1.slave)
  );
  debounce_timer #(.CNT_W(CNT_W), .DEFAULT_TC(DEF), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .tmr_if(b3.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    bit r, ts, ld;
    int val;
    bit eof, ebusy;
    int ecnt;
  } vec_t;
  vec_t vecs[$];

  // Reference model: a run is described only by how many cycles have
  // elapsed since it started (k). k=0 means idle; cycles 1..tc*P are the
  // counting window, cycle tc*P+1 is the expiry pulse.
  int m_tc   = DEF;
  int m_pend = 0;
  bit m_pvld = 1'b0;
  int m_k    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, ts, ld, input int val,
                     input bit eof, ebusy, input int ecnt);
    vec_t v;
    v.r = r; v.ts = ts; v.ld = ld; v.val = val;
    v.eof = eof; v.ebusy = ebusy; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic model_update(input bit r, ts, ld, input int val);
    int v;
    v = (val == 0) ? 1 : val;
    if (r) begin
      m_k = 0; m_tc = DEF; m_pvld = 1'b0;
    end else if (m_k == 0) begin
      if (ld) begin m_tc = v; m_pvld = 1'b0; end
      else if (m_pvld) begin m_tc = m_pend; m_pvld = 1'b0; end
      m_k = ts ? 1 : 0;
    end else begin
      if (ld) begin m_pend = v; m_pvld = 1'b1; end
      if (m_k == m_tc * MP + 1) m_k = 0;
      else if (!ts) m_k = 0;
      else m_k++;
    end
  endtask

  // One clock: check this cycle's outputs, apply inputs, advance the model.
  task automatic cycle(input bit r, ts, ld, input int val, input bit use_exp,
                       input bit eof, ebusy, input int ecnt, input string tag);
    bit mof, mbusy;
    int mcnt;
    @(negedge clk);
    if (m_k == 0) begin mof = 0; mbusy = 0; mcnt = 0; end
    else if (m_k <= m_tc * MP) begin mof = 0; mbusy = 1; mcnt = (m_k - 1) / MP; end
    else begin mof = 1; mbusy = 1; mcnt = 0; end
    chk({tag, "_model_of"},    {31'd0, b1.timerOF}, {31'd0, mof});
    chk({tag, "_model_busy"},  {31'd0, b1.busy},    {31'd0, mbusy});
    chk({tag, "_model_count"}, {24'd0, b1.count},   mcnt);
    if (use_exp) begin
      chk({tag, "_of"},    {31'd0, b1.timerOF}, {31'd0, eof});
      chk({tag, "_busy"},  {31'd0, b1.busy},    {31'd0, ebusy});
      chk({tag, "_count"}, {24'd0, b1.count},   ecnt);
    end
    rst = r;
    b1.timerstart = ts;
    b1.tc_load = ld;
    b1.tc_value = CNT_W'(val);
    @(posedge clk);
    model_update(r, ts, ld, val);
  endtask

  initial begin
    int hit, pulses;
    bit ts, r, ld;
    b1.timerstart = 0; b1.tc_load = 0; b1.tc_value = '0;
    b3.timerstart = 0; b3.tc_load = 0; b3.tc_value = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // PRESCALE=3, tc=2: expiry expected in cycle 7 only.
    b3.tc_load = 1; b3.tc_value = 8'd2;
    @(negedge clk);
    b3.tc_load = 0; b3.timerstart = 1;
    hit = -1; pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 6) chk("p3_count", {24'd0, b3.count}, (k - 1) / 3);
      if (k <= 7) chk("p3_busy", {31'd0, b3.busy}, 1);
      if (b3.timerOF === 1'b1) begin
        pulses++;
        if (hit < 0) hit = k;
      end
    end
    chk("p3_of_cycle", hit, 7);
    chk("p3_of_pulses", pulses, 1);
    b3.timerstart = 0;

    // Directed vectors (expected outputs are those seen in the cycle the
    // row's inputs are applied).
    add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,0,0);                // reset
    add(0,0,1,4, 0,0,0);                                     // load 4
    add(0,1,0,0, 0,0,0);                                     // cycle 0
    for (int i = 0; i < 4; i++) add(0,1,0,0, 0,1,i);         // cycles 1-4
    add(0,1,0,0, 1,1,0);                                     // cycle 5
    add(0,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,1,0);                // short pulse
    add(0,0,0,0, 0,1,1); add(0,0,0,0, 0,0,0);
    add(0,0,1,0, 0,0,0); add(0,1,0,0, 0,0,0);                // tc=0 -> 1
    add(0,1,0,0, 0,1,0); add(0,1,0,0, 1,1,0); add(0,0,0,0, 0,0,0);
    add(0,1,1,2, 0,0,0); add(0,1,0,0, 0,1,0);                // load+start
    add(0,1,0,0, 0,1,1); add(0,1,0,0, 1,1,0); add(0,0,0,0, 0,0,0);
    add(0,0,1,4, 0,0,0); add(0,1,0,0, 0,0,0);                // load while running
    add(0,1,1,8, 0,1,0);
    for (int i = 1; i < 4; i++) add(0,1,0,0, 0,1,i);
    add(0,1,0,0, 1,1,0); add(0,1,0,0, 0,0,0);
    for (int i = 0; i < 8; i++) add(0,1,0,0, 0,1,i);
    add(0,1,0,0, 1,1,0); add(0,0,0,0, 0,0,0);
    add(0,0,1,4, 0,0,0); add(0,1,0,0, 0,0,0);                // reset mid-run
    add(0,1,1,8, 0,1,0); add(0,1,0,0, 0,1,1);
    add(1,1,1,3, 0,1,2); add(0,0,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    for (int i = 0; i < DEF; i++) add(0,1,0,0, 0,1,i);
    add(0,1,0,0, 1,1,0); add(0,0,0,0, 0,0,0);

    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i].r, vecs[i].ts, vecs[i].ld, vecs[i].val, 1'b1,
            vecs[i].eof, vecs[i].ebusy, vecs[i].ecnt, "vec");

    // Randomized traffic against the reference model.
    ts = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ts = ~ts;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 19) == 0);
      cycle(r, ts, ld, int'($urandom_range(0, 9)), 1'b0, 0, 0, 0, "rnd");
    end
    cycle(0, 0, 0, 0, 1'b0, 0, 0, 0, "end");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
